// File: rtl/pkt_rr_sched_pkg.sv
// Shared constants for the per-output round-robin packet scheduler:
// default port count, select width and the two-state FSM encoding.
package pkt_rr_sched_pkg;

    localparam int PORT_NUB = 4;
    localparam int SEL_W    = $clog2(PORT_NUB);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

endpackage

// File: rtl/pkt_rr_sched_rr_pick.sv
// Rotating priority encoder: returns the first set request at or after ptr,
// wrapping cyclically, using the double-width shift of {req, req}.
module rr_pick #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SEL_W-1:0] off;
    logic [SEL_W:0]   sum;

    always_comb begin
        // Shifting the doubled vector right by ptr rotates req so that ptr lands in bit 0.
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = SEL_W'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (SEL_W + 1)'(N)) sum = sum - (SEL_W + 1)'(N);
        idx = sum[SEL_W-1:0];
        any = |req;
    end

endmodule

// File: rtl/pkt_rr_sched.sv
// Per-output packet scheduler: one round-robin arbiter and IDLE/LOCK FSM per
// output, holding the grant until the winner's end-of-packet beat is written.
module pkt_rr_sched #(
    parameter int PORT_NUB = pkt_rr_sched_pkg::PORT_NUB,
    parameter int SEL_W    = $clog2(PORT_NUB)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PORT_NUB*PORT_NUB-1:0] port_vaild,
    input  logic [PORT_NUB-1:0]          eop_in,
    input  logic [PORT_NUB-1:0]          full_in,
    output logic [PORT_NUB-1:0]          wr_en_out,
    output logic [PORT_NUB*SEL_W-1:0]    mux_sel,
    output logic [PORT_NUB*PORT_NUB-1:0] grant_out
);

    import pkt_rr_sched_pkg::*;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        return (v == SEL_W'(PORT_NUB - 1)) ? '0 : v + 1'b1;
    endfunction

    for (genvar i = 0; i < PORT_NUB; i++) begin : g_out
        logic [PORT_NUB-1:0] req_col;
        logic                cand_any;
        logic [SEL_W-1:0]    cand_idx;

        logic [0:0]          state_q,  state_d;
        logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
        logic [SEL_W-1:0]    owner_q,  owner_d;

        logic                wr;
        logic [SEL_W-1:0]    sel;
        logic [PORT_NUB-1:0] gnt_col;

        for (genvar j = 0; j < PORT_NUB; j++) begin : g_col
            assign req_col[j]               = port_vaild[j*PORT_NUB+i];
            assign grant_out[j*PORT_NUB+i]  = gnt_col[j];
        end

        rr_pick #(
            .N     (PORT_NUB),
            .SEL_W (SEL_W)
        ) u_pick (
            .req (req_col),
            .ptr (rr_ptr_q),
            .any (cand_any),
            .idx (cand_idx)
        );

        always_comb begin
            // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
            state_d  = state_q;
            rr_ptr_d = rr_ptr_q;
            owner_d  = owner_q;
            wr       = 1'b0;
            sel      = owner_q;
            gnt_col  = '0;

            // NOTE: outputs are gated by rst_n so an asserted reset silences the fabric at once,
            // even while requests are still present on the inputs.
            if (rst_n) begin
                if (state_q == ST_IDLE) begin
                    if (cand_any && !full_in[i]) begin
                        wr                = 1'b1;
                        sel               = cand_idx;
                        gnt_col[cand_idx] = 1'b1;
                        owner_d           = cand_idx;
                        if (eop_in[cand_idx]) rr_ptr_d = wrap_inc(cand_idx);
                        else                  state_d  = ST_LOCK;
                    end
                end else begin
                    // Locked: only the owner can move; a dropped request is a bubble, not an abort.
                    if (req_col[owner_q] && !full_in[i]) begin
                        wr               = 1'b1;
                        gnt_col[owner_q] = 1'b1;
                        if (eop_in[owner_q]) begin
                            state_d  = ST_IDLE;
                            rr_ptr_d = wrap_inc(owner_q);
                        end
                    end
                end
            end
        end

        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                rr_ptr_q <= '0;
                owner_q  <= '0;
            end else begin
                state_q  <= state_d;
                rr_ptr_q <= rr_ptr_d;
                owner_q  <= owner_d;
            end
        end

        assign wr_en_out[i]                = wr;
        assign mux_sel[i*SEL_W +: SEL_W]   = sel;
    end

    for (genvar j = 0; j < PORT_NUB; j++) begin : g_chk
        a_req_onehot : assert property (@(posedge clk) disable iff (!rst_n)
            $onehot0(port_vaild[j*PORT_NUB +: PORT_NUB]));
        a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
            $onehot0(grant_out[j*PORT_NUB +: PORT_NUB]));
    end

endmodule

// File: doc/pkt_rr_sched.md
Name: pkt_rr_sched

Overview:
- Per-output packet scheduler for the shared-cache switch. It replaces fixed-priority input selection with a round-robin arbiter for each output port.
- Once an input wins an output, the grant is held until that input's end-of-packet beat has been written. Packets therefore never interleave in an output queue.
- It drives the per-output mux selects and write enables of the switching fabric. It returns per-input grants so inputs can pop their buffers.

Parameters:
- PORT_NUB, 4: number of input ports and output ports (N). Must be at least 2.
- SEL_W, $clog2(PORT_NUB): width of one mux select field.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- port_vaild, input, N*N: request matrix. Bit j*N+i means input j has a beat for output i. Each input's N bits are at most one-hot.
- eop_in, input, N: bit j means input j's current beat is the last beat of its packet.
- full_in, input, N: bit i means output queue i cannot accept a beat this cycle.
- wr_en_out, output, N: bit i means a beat is written to output i this cycle.
- mux_sel, output, N*SEL_W: field i (bits (i+1)*SEL_W-1 : i*SEL_W) is the input index routed to output i.
- grant_out, output, N*N: bit j*N+i means input j's beat is consumed by output i this cycle. Inputs pop on this bit.

Behaviour:
- Reset (async, when rst_n=0), for every output i:
  - state=IDLE, rr_ptr[i]=0, owner[i]=0.
  - wr_en_out=0, grant_out=0, mux_sel=0.
- Per-output FSM, states IDLE and LOCK. Outputs are independent of each other.
- IDLE:
  - cand = first j, searching cyclically from rr_ptr[i] upward, with port_vaild[j*N+i]=1.
  - If any candidate exists and full_in[i]=0:
    - wr_en_out[i]=1, grant_out[cand*N+i]=1, mux_sel[i]=cand, owner[i]<=cand.
    - If eop_in[cand]=1: stay IDLE, rr_ptr[i]<=cand+1 mod N.
    - Else go to LOCK.
  - If a candidate exists but full_in[i]=1: no write, no grant, rr_ptr unchanged. The candidate is not committed, so arbitration is re-run next cycle.
  - If no candidate: mux_sel[i] holds owner[i].
- LOCK:
  - mux_sel[i]=owner[i]; other inputs are ignored.
  - A beat transfers when port_vaild[owner*N+i]=1 and full_in[i]=0.
    - This sets wr_en_out[i]=1 and grant_out[owner*N+i]=1.
    - If eop_in[owner] is set on the beat: go to IDLE, rr_ptr[i]<=owner+1 mod N.
  - Owner request drops mid-packet (bubble): hold LOCK with no write. There is no timeout.
- Latency: zero cycles. Grant, write enable and select are combinational from registered state plus the current cycle's inputs. State updates on the clock edge after a transfer.
- rr_ptr advances only on a completed packet, never on a stall.
- Single-beat packet (request and eop together, in IDLE): handled in one cycle, with no LOCK visit.
- Simultaneous completion and new request: after the eop beat the FSM is in IDLE. The next cycle arbitrates starting from the updated rr_ptr, giving one packet per cycle back-to-back.
- Wrap-around: a search from rr_ptr=N-1 checks N-1, then 0, 1, and so on. rr_ptr=N-1 plus 1 gives 0.
- Input request not one-hot (protocol violation): simulation assertion fires. RTL behaviour in that case is unspecified.
- Two outputs may not grant the same input in the same cycle. This follows from one-hot requests, and an assertion checks it.
- Reset asserted mid-packet: the LOCK is abandoned immediately and all outputs are forced to their reset values. Upstream drops any partial packet.

Decomposition:
- Shared package: PORT_NUB, SEL_W, and the state encoding (IDLE=1'b0, LOCK=1'b1).
- Sub-module rr_pick. It is combinational, parameter N. Inputs are req[N] and ptr[SEL_W]; outputs are any and idx[SEL_W]. It implements a rotating priority encoder (double-width mask trick).
- pkt_rr_sched instantiates one rr_pick plus one FSM, rr_ptr and owner register per output in a generate loop.

Test Plan (N=4):
- Fairness: inputs 0, 1 and 2 continuously request output 3 with 1-beat packets and full=0. Grants to output 3 rotate 0,1,2,0,1,2. wr_en_out[3]=1 every cycle.
- Lock hold: input 2 sends a 3-beat packet to output 0 while input 1 also requests output 0. mux_sel[0]=2 for 3 consecutive writes, then input 1 is granted on the next cycle. rr_ptr[0]=3 after input 2's packet.
- Backpressure: full_in[1]=1 for 5 cycles mid-packet (owner=3). wr_en_out[1]=0 and grant_out=0 throughout, state stays LOCK, and the packet resumes on the cycle full drops.
- Bubble: the owner deasserts its request for 2 cycles mid-packet while input 0 requests. Input 0 is not granted and the lock holds.
- Parallel outputs: inputs 0→1, 1→2, 2→3 and 3→0 all in the same cycle. All four wr_en_out bits=1, each mux_sel field holds the matching input, and there is no cross-interference.
- Reset mid-packet: assert rst_n=0 while in LOCK. All outputs go to 0 asynchronously. After release, arbitration starts from rr_ptr=0.
